// File: rtl/monitor_carga_pkg.sv
// Shared definitions for the critical battery-charge monitor.
// State encodings and the width rule for the summed total.
package monitor_carga_pkg;

  localparam logic [1:0] NORMAL      = 2'd0;
  localparam logic [1:0] SOSPECHA    = 2'd1;
  localparam logic [1:0] CRITICO     = 2'd2;
  localparam logic [1:0] RECUPERANDO = 2'd3;

  // Wide enough that N_BAT full-scale readings never overflow.
  function automatic int ancho_total(input int ancho, input int n_bat);
    int w;
    w = ancho + $clog2(n_bat);
    return (w < ancho + 1) ? ancho + 1 : w;
  endfunction

endpackage

// File: rtl/monitor_carga_critica_sumador.sv
// Combinational masked adder over N_BAT charge channels.
// Also flags enabled channels that read exactly zero.
module sumador_cargas
  import monitor_carga_pkg::*;
#(
  parameter int N_BAT = 2,
  parameter int ANCHO = 4
) (
  input  logic [N_BAT*ANCHO-1:0]               cargas,
  input  logic [N_BAT-1:0]                     mascara,
  output logic [ancho_total(ANCHO, N_BAT)-1:0] suma,
  output logic [N_BAT-1:0]                     vacias
);

  localparam int AT = ancho_total(ANCHO, N_BAT);

  always_comb begin
    suma   = '0;
    vacias = '0;
    for (int i = 0; i < N_BAT; i++) begin
      if (mascara[i]) begin
        suma      = suma + AT'(cargas[i*ANCHO +: ANCHO]);
        vacias[i] = (cargas[i*ANCHO +: ANCHO] == '0);
      end
    end
  end

endmodule

// File: rtl/monitor_carga_critica.sv
// Registered battery-charge total with a debounced, hysteretic
// critical warning for the power-management controller.
module monitor_carga_critica
  import monitor_carga_pkg::*;
#(
  parameter int N_BAT       = 2,
  parameter int ANCHO       = 4,
  parameter int UMBRAL_CRIT = 3,
  parameter int UMBRAL_LIB  = 5,
  parameter int N_CONFIRM   = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 muestra_valida,
  input  logic [N_BAT*ANCHO-1:0]               cargas,
  input  logic [N_BAT-1:0]                     mascara_bat,
  output logic [ancho_total(ANCHO, N_BAT)-1:0] carga_total,
  output logic                                 total_valido,
  output logic [N_BAT-1:0]                     bat_descargada,
  output logic                                 advertencia_critica,
  output logic                                 evento_critico,
  output logic [1:0]                           estado
);

  localparam int AT = ancho_total(ANCHO, N_BAT);
  localparam int CW = $clog2(N_CONFIRM + 1);

  localparam logic [AT-1:0] U_CRIT  = AT'(UMBRAL_CRIT);
  localparam logic [AT-1:0] U_LIB   = AT'(UMBRAL_LIB);
  localparam logic [CW-1:0] CNT_FIN = CW'(N_CONFIRM);

  logic [AT-1:0]    suma;
  logic [N_BAT-1:0] vacias;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_inc;
  logic [CW-1:0]    cnt_nx;
  logic [1:0]       est_nx;
  logic             entra;
  logic             es_crit;
  logic             es_lib;

  sumador_cargas #(
    .N_BAT (N_BAT),
    .ANCHO (ANCHO)
  ) u_sumador (
    .cargas  (cargas),
    .mascara (mascara_bat),
    .suma    (suma),
    .vacias  (vacias)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carga_total    <= '0;
      bat_descargada <= '0;
      total_valido   <= 1'b0;
    end else begin
      total_valido <= muestra_valida;
      if (muestra_valida) begin
        carga_total    <= suma;
        bat_descargada <= vacias;
      end
    end
  end

  assign es_crit = (carga_total <= U_CRIT);
  assign es_lib  = (carga_total >= U_LIB);
  assign cnt_inc = (cnt == CNT_FIN) ? cnt : cnt + CW'(1);

  always_comb begin
    est_nx = estado;
    cnt_nx = cnt;
    entra  = 1'b0;
    unique case (estado)
      NORMAL: begin
        cnt_nx = '0;
        if (es_crit) begin
          if (N_CONFIRM == 1) begin
            est_nx = CRITICO;
            entra  = 1'b1;
          end else begin
            est_nx = SOSPECHA;
            cnt_nx = CW'(1);
          end
        end
      end
      SOSPECHA: begin
        cnt_nx = '0;
        if (!es_crit) begin
          est_nx = NORMAL;
        end else if (cnt_inc == CNT_FIN) begin
          est_nx = CRITICO;
          entra  = 1'b1;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      CRITICO: begin
        if (es_lib) begin
          if (N_CONFIRM == 1) begin
            est_nx = NORMAL;
            cnt_nx = '0;
          end else begin
            est_nx = RECUPERANDO;
            cnt_nx = CW'(1);
          end
        end
      end
      RECUPERANDO: begin
        cnt_nx = '0;
        if (!es_lib) begin
          // Relapse keeps the warning up and raises no new event.
          est_nx = CRITICO;
        end else if (cnt_inc == CNT_FIN) begin
          est_nx = NORMAL;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      default: begin
        est_nx = NORMAL;
        cnt_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado              <= NORMAL;
      cnt                 <= '0;
      advertencia_critica <= 1'b0;
      evento_critico      <= 1'b0;
    end else if (total_valido) begin
      estado              <= est_nx;
      cnt                 <= cnt_nx;
      advertencia_critica <= est_nx[1];
      evento_critico      <= entra;
    end else begin
      evento_critico <= 1'b0;
    end
  end

endmodule

// File: tb/tb_monitor_carga_critica.sv
// Scoreboard bench: default instance plus a 4x6-bit, N_CONFIRM=1 one.
// Expected responses come from a run-length model of the warning.
module tb_monitor_carga_critica;

  typedef struct {
    int total;
    int desc;
    int est;
    int adv;
    int ev;
  } exp_t;

  logic       clk;
  logic       rst;

  logic       valid_a;
  logic [7:0] cargas_a;
  logic [1:0] mask_a;
  logic [4:0] total_a;
  logic       tv_a;
  logic [1:0] desc_a;
  logic       adv_a;
  logic       ev_a;
  logic [1:0] est_a;

  logic        valid_b;
  logic [23:0] cargas_b;
  logic [3:0]  mask_b;
  logic [7:0]  total_b;
  logic        tv_b;
  logic [3:0]  desc_b;
  logic        adv_b;
  logic        ev_b;
  logic [1:0]  est_b;

  int   n_chk;
  int   n_pass;
  exp_t qa[$];
  exp_t qb[$];
  exp_t fa;
  exp_t fb;
  bit   pend_a;
  bit   pend_b;
  int   last_a;
  int   last_b;
  bit   warn_a;
  bit   warn_b;
  int   run_a;
  int   run_b;

  monitor_carga_critica dut_a (
    .clk                 (clk),
    .rst                 (rst),
    .muestra_valida      (valid_a),
    .cargas              (cargas_a),
    .mascara_bat         (mask_a),
    .carga_total         (total_a),
    .total_valido        (tv_a),
    .bat_descargada      (desc_a),
    .advertencia_critica (adv_a),
    .evento_critico      (ev_a),
    .estado              (est_a)
  );

  monitor_carga_critica #(
    .N_BAT       (4),
    .ANCHO       (6),
    .UMBRAL_CRIT (10),
    .UMBRAL_LIB  (20),
    .N_CONFIRM   (1)
  ) dut_b (
    .clk                 (clk),
    .rst                 (rst),
    .muestra_valida      (valid_b),
    .cargas              (cargas_b),
    .mascara_bat         (mask_b),
    .carga_total         (total_b),
    .total_valido        (tv_b),
    .bat_descargada      (desc_b),
    .advertencia_critica (adv_b),
    .evento_critico      (ev_b),
    .estado              (est_b)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string n, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", n, act, exp);
  endfunction

  // Warning follows runs of N consecutive qualifying samples.
  function automatic void model_step(inout bit warn, inout int run,
                                     input int t, input int c, input int l,
                                     input int nc, inout exp_t e);
    bit ev;
    ev = 0;
    if (!warn) begin
      run = (t <= c) ? run + 1 : 0;
      if (run == nc) begin
        warn = 1;
        run  = 0;
        ev   = 1;
      end
    end else begin
      run = (t >= l) ? run + 1 : 0;
      if (run == nc) begin
        warn = 0;
        run  = 0;
      end
    end
    e.est = warn ? ((run > 0) ? 3 : 2) : ((run > 0) ? 1 : 0);
    e.adv = warn;
    e.ev  = ev;
  endfunction

  task automatic send_a(input int c0, input int c1, input logic [1:0] m);
    exp_t e;
    cargas_a = {4'(c1), 4'(c0)};
    mask_a   = m;
    valid_a  = 1;
    @(posedge clk);
    e.total = (m[0] ? c0 : 0) + (m[1] ? c1 : 0);
    e.desc  = ((m[0] && c0 == 0) ? 1 : 0) + ((m[1] && c1 == 0) ? 2 : 0);
    model_step(warn_a, run_a, e.total, 3, 5, 3, e);
    qa.push_back(e);
    #1 valid_a = 0;
  endtask

  task automatic send_b(input int c0, input int c1, input int c2,
                        input int c3, input logic [3:0] m);
    exp_t e;
    int   c[4];
    c = '{c0, c1, c2, c3};
    cargas_b = {6'(c3), 6'(c2), 6'(c1), 6'(c0)};
    mask_b   = m;
    valid_b  = 1;
    @(posedge clk);
    e.total = 0;
    e.desc  = 0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        e.total += c[i];
        if (c[i] == 0) e.desc += (1 << i);
      end
    end
    model_step(warn_b, run_b, e.total, 10, 20, 1, e);
    qb.push_back(e);
    #1 valid_b = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_models();
    qa.delete();
    qb.delete();
    pend_a = 0;
    pend_b = 0;
    last_a = 0;
    last_b = 0;
    warn_a = 0;
    warn_b = 0;
    run_a  = 0;
    run_b  = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_total_a"}, int'(total_a), 0);
    chk({tag, "_tv_a"}, int'(tv_a), 0);
    chk({tag, "_desc_a"}, int'(desc_a), 0);
    chk({tag, "_adv_a"}, int'(adv_a), 0);
    chk({tag, "_ev_a"}, int'(ev_a), 0);
    chk({tag, "_est_a"}, int'(est_a), 0);
    chk({tag, "_total_b"}, int'(total_b), 0);
    chk({tag, "_est_b"}, int'(est_b), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (pend_a) begin
        chk("a_estado", int'(est_a), fa.est);
        chk("a_advertencia", int'(adv_a), fa.adv);
        chk("a_evento", int'(ev_a), fa.ev);
        last_a = fa.est;
        pend_a = 0;
      end else begin
        chk("a_evento_idle", int'(ev_a), 0);
        chk("a_estado_idle", int'(est_a), last_a);
      end
      if (tv_a) begin
        if (qa.size() == 0) begin
          n_chk++;
          $display("FAIL a_unexpected_valid: got total %0d expected no output",
                   total_a);
        end else begin
          fa = qa.pop_front();
          chk("a_carga_total", int'(total_a), fa.total);
          chk("a_bat_descargada", int'(desc_a), fa.desc);
          pend_a = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (pend_b) begin
        chk("b_estado", int'(est_b), fb.est);
        chk("b_advertencia", int'(adv_b), fb.adv);
        chk("b_evento", int'(ev_b), fb.ev);
        last_b = fb.est;
        pend_b = 0;
      end else begin
        chk("b_evento_idle", int'(ev_b), 0);
        chk("b_estado_idle", int'(est_b), last_b);
      end
      if (tv_b) begin
        if (qb.size() == 0) begin
          n_chk++;
          $display("FAIL b_unexpected_valid: got total %0d expected no output",
                   total_b);
        end else begin
          fb = qb.pop_front();
          chk("b_carga_total", int'(total_b), fb.total);
          chk("b_bat_descargada", int'(desc_b), fb.desc);
          pend_b = 1;
        end
      end
    end
  end

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    clk      = 0;
    rst      = 0;
    valid_a  = 0;
    cargas_a = '0;
    mask_a   = '0;
    valid_b  = 0;
    cargas_b = '0;
    mask_b   = '0;
    clear_models();
    #1 rst = 1;
    #1 check_reset_outputs("rst_init");
    @(posedge clk);
    #1 rst = 0;

    // Confirmation, hysteresis band, release.
    repeat (3) send_a(1, 2, 2'b11);
    repeat (4) send_a(2, 2, 2'b11);
    repeat (3) send_a(3, 2, 2'b11);
    send_a(1, 2, 2'b11);
    send_a(1, 2, 2'b11);
    send_a(4, 3, 2'b11);
    // Relapse from recovery raises no second event.
    repeat (3) send_a(0, 1, 2'b11);
    send_a(3, 2, 2'b11);
    send_a(3, 2, 2'b11);
    send_a(2, 2, 2'b11);
    repeat (3) send_a(3, 2, 2'b11);
    // Masking, empties, full scale.
    send_a(0, 7, 2'b11);
    send_a(7, 15, 2'b01);
    send_a(9, 9, 2'b00);
    send_a(15, 15, 2'b11);
    send_a(15, 15, 2'b11);
    // Idle gaps do not break a confirmation run.
    for (int i = 0; i < 3; i++) begin
      send_a(1, 1, 2'b11);
      idle(5);
    end
    repeat (3) send_a(8, 8, 2'b11);
    idle(2);

    // Asynchronous reset inside SOSPECHA with cnt = 2.
    send_a(1, 0, 2'b11);
    send_a(1, 0, 2'b11);
    idle(2);
    #2 rst = 1;
    #1 check_reset_outputs("rst_async");
    clear_models();
    @(posedge clk);
    #1 rst = 0;
    send_a(1, 1, 2'b11);
    send_a(1, 1, 2'b11);
    idle(2);
    send_a(1, 1, 2'b11);
    idle(2);

    for (int i = 0; i < 150; i++) begin
      send_a($urandom_range(0, ($urandom % 3 == 0) ? 15 : 3),
             $urandom_range(0, ($urandom % 3 == 0) ? 15 : 3),
             2'($urandom));
      if ($urandom % 4 == 0) idle($urandom_range(1, 3));
    end
    idle(3);

    send_b(63, 63, 63, 63, 4'b1111);
    send_b(2, 2, 2, 2, 4'b1111);
    send_b(3, 3, 3, 3, 4'b1111);
    send_b(5, 5, 5, 5, 4'b1111);
    send_b(0, 40, 0, 1, 4'b0110);
    send_b(0, 40, 0, 1, 4'b1011);
    for (int i = 0; i < 40; i++) begin
      send_b($urandom_range(0, 8), $urandom_range(0, 8),
             $urandom_range(0, 8), $urandom_range(0, 63), 4'($urandom));
      if ($urandom % 3 == 0) idle(1);
    end
    idle(3);

    chk("a_scoreboard_drained", qa.size(), 0);
    chk("b_scoreboard_drained", qb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/monitor_carga_critica.md
Name: monitor_carga_critica

Overview:
- Parametrised, clocked successor of the two-battery critical-charge detector.
- Sums N_BAT masked battery charge readings of ANCHO bits each and registers the total.
- Raises a critical warning with confirmation (debounce) and hysteresis, instead of the raw combinational "sum <= 3" flag.
- Sits between the battery ADC sampling logic and the power-management controller.

Parameters:
- N_BAT, 2, number of battery channels (>= 1).
- ANCHO, 4, bits per battery charge reading.
- UMBRAL_CRIT, 3, total at or below which a sample counts as critical.
- UMBRAL_LIB, 5, total at or above which a sample counts as release. Must be > UMBRAL_CRIT.
- N_CONFIRM, 3, consecutive qualifying samples required to enter or leave the warning (>= 1).
- Derived constant ANCHO_TOTAL = ANCHO + $clog2(N_BAT), with minimum ANCHO+1. The total never overflows.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- muestra_valida  input  1  cargas/mascara_bat hold a new sample this cycle.
- cargas  input  N_BAT*ANCHO  packed charges; channel i occupies bits [i*ANCHO +: ANCHO].
- mascara_bat  input  N_BAT  1 = channel included in the sum; 0 = contributes 0.
- carga_total  output  ANCHO_TOTAL  registered masked sum of the last valid sample.
- total_valido  output  1  one-cycle pulse, 1 cycle after muestra_valida.
- bat_descargada  output  N_BAT  registered per channel: enabled and charge == 0, updated with carga_total.
- advertencia_critica  output  1  registered; high in CRITICO or RECUPERANDO.
- evento_critico  output  1  one-cycle pulse on the transition into CRITICO.
- estado  output  2  current FSM state, for debug.

Behaviour:
- Reset: rst is asynchronous, active-high. It clears all of the following:
  - carga_total = 0, total_valido = 0, bat_descargada = 0.
  - advertencia_critica = 0, evento_critico = 0.
  - estado = NORMAL (0), confirmation counter = 0.
  - Reset mid-confirmation discards the partial count.
- Stage 1: on an edge with muestra_valida = 1, register carga_total, bat_descargada and total_valido = 1.
  - With muestra_valida = 0, total_valido = 0 and carga_total and bat_descargada hold their values.
- Stage 2: the FSM advances only on edges where total_valido = 1. It evaluates the registered carga_total.
  - Latency: sample edge k to first FSM effect at edge k+1.
  - Idle cycles between samples neither advance nor reset the counter.
- Sample classes:
  - crit: carga_total <= UMBRAL_CRIT.
  - lib: carga_total >= UMBRAL_LIB.
  - Values in between are neither (hysteresis band).
- FSM states and transitions:
  - NORMAL (0):
    - crit: cnt = 1; go to SOSPECHA, or directly to CRITICO if N_CONFIRM == 1.
    - otherwise: stay, cnt = 0.
  - SOSPECHA (1):
    - crit: cnt + 1; when the result equals N_CONFIRM, go to CRITICO with cnt = 0.
    - otherwise: go to NORMAL, cnt = 0.
  - CRITICO (2):
    - lib: cnt = 1; go to RECUPERANDO, or directly to NORMAL if N_CONFIRM == 1.
    - otherwise (including the hysteresis band): stay.
  - RECUPERANDO (3):
    - lib: cnt + 1; when the result equals N_CONFIRM, go to NORMAL with cnt = 0.
    - otherwise: go back to CRITICO, cnt = 0.
- Outputs from the FSM:
  - advertencia_critica = (estado == CRITICO) or (estado == RECUPERANDO), registered with the state.
  - evento_critico pulses exactly on the edge that enters CRITICO from SOSPECHA or NORMAL. It does not pulse on RECUPERANDO -> CRITICO.
- Counter width: $clog2(N_CONFIRM+1). It saturates and never wraps.
- All channels masked: total = 0, which is treated as critical (intended: no usable supply).
- Full-scale inputs: all channels at 2^ANCHO-1 sum without truncation (N_BAT=2, ANCHO=4 gives 30 in 5 bits).
- Changing mascara_bat between samples affects only the next valid sample.

Decomposition:
- Package monitor_carga_pkg holds:
  - state encodings NORMAL / SOSPECHA / CRITICO / RECUPERANDO as 2-bit localparams;
  - the ANCHO_TOTAL computation function.
- One sub-module, sumador_cargas: combinational masked adder over N_BAT channels, parameters N_BAT and ANCHO. It is instantiated once, ahead of the stage 1 registers.
- The FSM and counter stay in the top module.

Test Plan:
All scenarios use default parameters unless stated.
- Reset: assert rst asynchronously mid-cycle during SOSPECHA (cnt = 2) -> all outputs 0 and estado = 0 immediately, without waiting for a clock edge. After release, a crit sample restarts at cnt = 1.
- Confirmation: three consecutive samples (1,2) give total 3:
  - advertencia_critica rises 1 cycle after the third total_valido;
  - evento_critico is a single pulse;
  - two crit samples followed by (4,3) = 7 return estado to 0 with no warning.
- Hysteresis:
  - in CRITICO, samples totalling 4 keep the warning indefinitely;
  - (3,2) = 5 three times clears the warning;
  - 5, 5, 4 returns to CRITICO without an evento_critico pulse.
- Masking and empties:
  - cargas = (0,7), mascara = 2'b11 -> carga_total = 7, bat_descargada = 2'b01;
  - mascara = 2'b01 on (7,15) -> total 7;
  - mascara = 2'b00 -> total 0, which counts as crit.
- Width and idle:
  - (15,15) -> carga_total = 30 (5'b11110);
  - crit samples separated by 5 idle cycles still confirm after the third sample.
- Parametrised run with N_BAT=4, ANCHO=6, UMBRAL_CRIT=10, UMBRAL_LIB=20, N_CONFIRM=1:
  - (63,63,63,63) -> total 252 in 8 bits;
  - (2,2,2,2) -> CRITICO immediately with an evento_critico pulse;
  - (5,5,5,5) -> NORMAL immediately.
